regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Multi-port integer register file with pending-write scoreboard, for the dual-issue pipeline.
//  NUM_RD read ports and NUM_WR write ports, with same-cycle write->read forwarding.
//  Hardwired zero register x0.
//  Per-register busy bit set at issue, cleared at writeback. Decode uses it to detect RAW hazards and stall.
// PARAMETERS
//  REG_WIDTH  32  data width of each register
//  NUM_REGS   32  number of architectural registers (power of 2, >=2)
//  NUM_RD      4  number of read ports
//  NUM_WR      2  number of write ports (index NUM_WR-1 = youngest/highest priority)
//  AW         $clog2(NUM_REGS)  register address width (derived, localparam)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  rd_addr    in   NUM_RD*AW       read addresses, port i at [i*AW +: AW]
//  rd_data    out  NUM_RD*REG_WIDTH read data, combinational, port i at [i*REG_WIDTH +: REG_WIDTH]
//  rd_busy    out  NUM_RD          1 = read register still has an outstanding producer
//  wr_en      in   NUM_WR          write enables
//  wr_addr    in   NUM_WR*AW       write addresses
//  wr_data    in   NUM_WR*REG_WIDTH write data
//  iss_en     in   1               issue of an instruction with a destination register
//  iss_addr   in   AW              destination register being issued (marks busy)
//  flush      in   1               pipeline flush: clear all busy bits
//  busy_cnt   out  AW+1            registered count of busy registers (perf/debug)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - All registers go to 0, all busy bits go to 0, busy_cnt goes to 0.
//   - rd_data reads 0 and rd_busy reads 0 while in reset.
//  Write:
//   - At posedge clk, reg[wr_addr[j]] <= wr_data[j] for each j with wr_en[j] and wr_addr[j]!=0.
//   - Two ports writing the same register in one cycle: the highest j wins. Others are dropped silently.
//  Read (combinational, 0 cycle latency):
//   - rd_addr==0 returns 0 and rd_busy=0.
//   - Otherwise, if any enabled write port targets rd_addr this cycle, return wr_data of the
//     highest such j (forwarding). Else return the stored value.
//  Scoreboard (busy[0] is constant 0):
//   - Write-clear: busy[r] <= 0 at posedge when any wr_en[j] targets r.
//   - Issue-set: busy[r] <= 1 at posedge when iss_en and iss_addr==r, r!=0.
//   - Issue and write to the same r in the same cycle: set wins, because the new producer is outstanding.
//   - flush=1: all busy bits <= 0. Takes priority over set and clear.
//     An iss_en in the same cycle as flush is discarded. Writes still update the data array.
//   - rd_busy[i] = busy[rd_addr[i]] & ~(any wr_en[j] targeting rd_addr[i] this cycle).
//     A value forwarded in the same cycle is therefore not reported busy.
//  busy_cnt:
//   - Registered popcount of the next-state busy vector, valid the cycle after the update.
//   - Range 0..NUM_REGS-1. Never wraps.
//  Out-of-range addresses cannot occur because NUM_REGS=2**AW.
//  No X propagation: unused ports with wr_en=0 have no effect.
// TESTING
//  T1 Reset: assert rst_n=0 mid-run after writing x5=0xDEAD -> rd_data=0 on all ports, rd_busy=0,
//     busy_cnt=0, all immediately and asynchronously.
//  T2 Write/read: wr_en[0], x7=0x1234. Next cycle rd_addr[2]=7 -> 0x1234.
//     Also write x0=0xFFFF -> rd of x0 returns 0.
//  T3 Forward/priority: same cycle wr0 x3=0xAAAA and wr1 x3=0xBBBB with rd_addr[0]=3
//     -> rd_data[0]=0xBBBB that cycle and stored 0xBBBB afterwards.
//  T4 Scoreboard: iss x9 -> next cycle rd_busy=1 for x9 and busy_cnt=1.
//     Write x9 -> rd_busy=0 in the write cycle; busy_cnt=0 one cycle later.
//  T5 Collision: iss x4 and write x4 in the same cycle -> x4 busy next cycle, data updated.
//     iss x0 -> never busy.
//  T6 Flush: iss x1,x2,x3 -> busy_cnt=3.
//     flush together with iss x5 -> all busy bits 0, busy_cnt=0, x5 not busy.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write forwarding and a
// per-register pending-write scoreboard used by decode for RAW hazard stalls.
module regfile_mp #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD*AW-1:0]        rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*AW-1:0]        wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
  input  logic                        iss_en,
  input  logic [AW-1:0]               iss_addr,
  input  logic                        flush,
  output logic [AW:0]                 busy_cnt
);

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [AW:0]          busy_cnt_q, busy_cnt_d;

  logic [AW-1:0]        ra [NUM_RD];
  logic [AW-1:0]        wa [NUM_WR];
  logic [REG_WIDTH-1:0] wd [NUM_WR];
  logic [REG_WIDTH-1:0] fwd_data [NUM_RD];
  logic [NUM_RD-1:0]    fwd_hit;

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) ra[i] = rd_addr[i*AW +: AW];
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j] = wr_addr[j*AW +: AW];
      wd[j] = wr_data[j*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Ascending port order makes the highest enabled write port win.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wa[j] != '0)) regs_d[wa[j]] = wd[j];
    end
    regs_d[0] = '0;
  end

  // Issue-set overrides write-clear (a newer producer is outstanding); flush overrides both.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wa[j]] = 1'b0;
    end
    if (iss_en) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[r]);
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      fwd_hit[i]  = 1'b0;
      fwd_data[i] = regs_q[ra[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wa[j] == ra[i])) begin
          fwd_hit[i]  = 1'b1;
          fwd_data[i] = wd[j];
        end
      end
      // Outputs are forced quiet while reset is asserted, even if writes are presented.
      if (rst_n && (ra[i] != '0)) begin
        rd_data[i*REG_WIDTH +: REG_WIDTH] = fwd_data[i];
        rd_busy[i] = busy_q[ra[i]] & ~fwd_hit[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule
